// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

    localparam int INST_W       = 32;
    localparam int PC_STEP      = 4;
    localparam int ENTRY_ADDR_W = 64;

    // Queue entry; PCs narrower than ENTRY_ADDR_W are stored zero-extended.
    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] pc;
        logic [INST_W-1:0]       inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries; clear beats push and pop.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  ifq_entry_t push_entry,
    input  logic       pop,
    output logic [AW:0] count,
    output ifq_entry_t head
);

    ifq_entry_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop && (count != '0);
    // A simultaneous pop frees the slot, so a full FIFO may still accept.
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear && do_push) mem[wr_ptr] <= push_entry;
    end

    // Empty queue presents zeros so the head is defined straight out of reset.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues credited imem requests, buffers responses.
// Optional IFQ_PERF_COUNTERS_EN adds stall and dropped-response counters.
module instruction_fetch_queue
    import ifq_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
`ifdef IFQ_PERF_COUNTERS_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_dropped
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     count;
    logic              req_fire;
    logic              resp_drop;
    logic              push;
    logic              pop;
    ifq_entry_t        push_entry;
    ifq_entry_t        head;

    // Credit counts queued plus in-flight entries, so the queue can never overflow.
    assign imem_req_valid = !reset && !redirect_valid &&
                            (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop = imem_resp_valid && (redirect_valid || (drop_cnt != '0));
    assign push      = imem_resp_valid && !resp_drop;
    assign inst_valid = (count != '0);
    assign pop       = inst_valid && inst_ready;

    assign push_entry.pc   = ENTRY_ADDR_W'(resp_pc);
    assign push_entry.inst = imem_resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle's response is stale.
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            outstanding <= outstanding - CW'(imem_resp_valid);
            drop_cnt    <= outstanding - CW'(imem_resp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            if (push)     resp_pc  <= resp_pc + ADDR_W'(PC_STEP);
            if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
        end
    end

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

    assign inst_data = head.inst;
    assign inst_pc   = head.pc[ADDR_W-1:0];

`ifdef IFQ_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_dropped      <= '0;
        end else begin
            if (inst_ready && !inst_valid && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (resp_drop && (perf_dropped != '1))
                perf_dropped <= perf_dropped + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench with a queue-level reference model and an in-bench imem model.
module tb_instruction_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
`ifdef IFQ_PERF_COUNTERS_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_dropped;
`endif

    instruction_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
`ifdef IFQ_PERF_COUNTERS_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_dropped      (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int due; } mreq_t;
    typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;

    mreq_t mem_q[$];
    ent_t  mq[$];
    ent_t  popped[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    int n_req = 0;
    bit model_ok = 0;
    logic [63:0] m_fetch;
    logic [63:0] m_resp;
    int m_out, m_drop, m_dropped_total, m_stall;

    function automatic logic [31:0] mem_data(logic [63:0] a);
        return 32'h1300_0013 ^ a[31:0];
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: present memory response, compare, then advance the model.
    task automatic step();
        bit   exp_req, exp_iv, resp, fire, pop;
        ent_t e;
        resp = !reset && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_data(mem_q[0].addr) : 32'h0;
        #1;
        exp_req = !reset && !redirect_valid && ((mq.size() + m_out) < DEPTH);
        exp_iv  = (mq.size() != 0);
        if (model_ok) begin
            chk("req_valid", imem_req_valid, exp_req);
            if (exp_req) chk("req_addr", imem_req_addr, m_fetch);
            chk("inst_valid", inst_valid, exp_iv);
            if (exp_iv) begin
                chk("inst_pc", inst_pc, mq[0].pc);
                chk("inst_data", inst_data, mq[0].inst);
            end
`ifdef IFQ_PERF_COUNTERS_EN
            chk("perf_stall", perf_stall_cycles, m_stall);
            chk("perf_dropped", perf_dropped, m_dropped_total);
`endif
        end
        fire = exp_req && imem_req_ready;
        pop  = exp_iv && inst_ready;
        if (reset) begin
            mq.delete(); mem_q.delete();
            m_fetch = RESET_PC; m_resp = RESET_PC;
            m_out = 0; m_drop = 0; m_dropped_total = 0; m_stall = 0;
            model_ok = 1;
        end else begin
            if (inst_ready && !exp_iv) m_stall++;
            if (resp) begin void'(mem_q.pop_front()); m_out--; end
            if (redirect_valid) begin
                mq.delete();
                if (resp) m_dropped_total++;
                m_drop = m_out;
                m_fetch = redirect_pc; m_resp = redirect_pc;
            end else begin
                if (pop) popped.push_back(mq.pop_front());
                if (resp) begin
                    if (m_drop != 0) begin
                        m_drop--; m_dropped_total++;
                    end else begin
                        e.pc = m_resp; e.inst = mem_data(m_resp);
                        mq.push_back(e);
                        m_resp += 64'd4;
                    end
                end
                if (fire) begin
                    mem_q.push_back('{addr: m_fetch, due: cyc + lat});
                    m_fetch += 64'd4;
                    m_out++; n_req++;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0;
        step();
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst_pc", inst_pc, 64'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_req_valid", imem_req_valid, 1'b0);
`ifdef IFQ_PERF_COUNTERS_EN
        chk("rst_perf_stall", perf_stall_cycles, 32'h0);
`endif
        reset = 1'b0;
        #1;
        chk("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, RESET_PC);
        popped.delete();
        n_req = 0;
    endtask

    initial begin
        int d0;
        reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        @(negedge clk);

        // Steady stream with a 1-cycle memory.
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        repeat (20) step();
        chk("stream_pops", popped.size(), 18);
        chk("stream_pc0", popped[0].pc, 64'h0);
        chk("stream_pc1", popped[1].pc, 64'h4);
        chk("stream_pc2", popped[2].pc, 64'h8);
        chk("stream_data2", popped[2].inst, 32'h1300_001B);

        // Backpressure fills the credit window, then drains in order.
        do_reset();
        inst_ready = 1'b0;
        repeat (10) step();
        chk("bp_requests", n_req, 4);
        chk("bp_req_valid", imem_req_valid, 1'b0);
        chk("bp_head_pc", inst_pc, 64'h0);
        inst_ready = 1'b1;
        repeat (8) step();
        chk("bp_drain_n", popped.size() >= 4, 1'b1);
        chk("bp_drain0", popped[0].pc, 64'h0);
        chk("bp_drain1", popped[1].pc, 64'h4);
        chk("bp_drain2", popped[2].pc, 64'h8);
        chk("bp_drain3", popped[3].pc, 64'hC);

        // Redirect with three responses in flight on a slow memory.
        lat = 4;
        do_reset();
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        d0 = m_dropped_total;
        step();
        redirect_valid = 1'b0;
        popped.delete();
        repeat (15) step();
        chk("rd3_dropped", m_dropped_total - d0, 3);
        chk("rd3_first_pc", popped[0].pc, 64'h100);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        do_reset();
        repeat (5) step();
        redirect_valid = 1'b1; redirect_pc = 64'h200;
        d0 = m_dropped_total;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rdx_inst_valid", inst_valid, 1'b0);
        chk("rdx_req_valid", imem_req_valid, 1'b1);
        chk("rdx_req_addr", imem_req_addr, 64'h200);
        chk("rdx_dropped", m_dropped_total - d0, 1);
        popped.delete();
        repeat (6) step();
        chk("rdx_first_pc", popped[0].pc, 64'h200);

        // Reset in the middle of a stream.
        lat = 2;
        repeat (6) step();
        do_reset();
        repeat (6) step();
        chk("mid_rst_first_pc", popped[0].pc, RESET_PC);

`ifdef IFQ_PERF_COUNTERS_EN
        // Five empty-with-ready cycles, then two dropped responses.
        lat = 3; imem_req_ready = 1'b0; inst_ready = 1'b1;
        do_reset();
        repeat (5) step();
        chk("perf_stall5", perf_stall_cycles, 32'd5);
        imem_req_ready = 1'b1;
        repeat (2) step();
        redirect_valid = 1'b1; redirect_pc = 64'h300;
        step();
        redirect_valid = 1'b0;
        repeat (6) step();
        chk("perf_dropped2", perf_dropped, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
